// File: rtl/line_fill_buffer.sv
// -----------------------------------------------------------------------------
// line_fill_buffer
//
// Line-fill engine between the instruction-cache controller and the AXI4 read
// channel. A fill starts on LB_Enable and fetches one cache line as a
// critical-word-first WRAP burst. LB_FirstWord rises as soon as the missed word
// has arrived, so the core can restart early. The assembled line is held until
// the controller drops LB_Enable to acknowledge that it has been written.
//
// Optional build macro: LFB_RESP_CHECK_EN
//   defined   : LB_Error flags RRESP errors and misplaced or missing RLAST
//               (sticky until the next fill starts)
//   undefined : RRESP and RLAST are ignored and LB_Error is tied to 0
//
// Ports
//   Clk, Rst          clock (rising edge), asynchronous active-low reset
//   LB_Enable         request / hold level from the cache controller
//   WordAddress       byte address of the missed word, sampled at fill start
//   LB_FirstWord      critical word is valid in CritData
//   LB_Completed      whole line is valid in LineData
//   LineAddress       line base address of the current or last fill
//   CritData          critical (missed) word
//   LineData          assembled line, word i at [i*DATA_W +: DATA_W]
//   LB_Error          response error seen during the fill
//   AR*/R*            AXI4 read address and read data channels (master side)
// -----------------------------------------------------------------------------
module line_fill_buffer #(
  parameter int WORDS_PER_LINE = 8,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             LB_Enable,
  input  logic [ADDR_W-1:0]                WordAddress,
  output logic                             LB_FirstWord,
  output logic                             LB_Completed,
  output logic [ADDR_W-1:0]                LineAddress,
  output logic [DATA_W-1:0]                CritData,
  output logic [WORDS_PER_LINE*DATA_W-1:0] LineData,
  output logic                             LB_Error,
  output logic [ADDR_W-1:0]                ARADDR,
  output logic [7:0]                       ARLEN,
  output logic [2:0]                       ARSIZE,
  output logic [1:0]                       ARBURST,
  output logic                             ARVALID,
  input  logic                             ARREADY,
  input  logic [DATA_W-1:0]                RDATA,
  input  logic [1:0]                       RRESP,
  input  logic                             RLAST,
  input  logic                             RVALID,
  output logic                             RREADY
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic             abort_reg;   // controller dropped LB_Enable mid-fill
  logic [IDX_W-1:0] beat_reg;
  logic [IDX_W-1:0] crit_reg;

  logic             beat_fire;
  logic             last_beat;
  logic [IDX_W-1:0] slot_idx;

  // Burst shape never changes: one full line, word-sized beats, WRAP.
  assign ARLEN   = 8'(WORDS_PER_LINE - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b10;

  // RREADY is high throughout DATA, so a valid beat is always accepted there.
  assign beat_fire = (state_reg == S_DATA) && RVALID;
  assign last_beat = (beat_reg == LAST_BEAT);
  // Natural wrap of the IDX_W-bit sum gives the modulo-line slot.
  assign slot_idx  = crit_reg + beat_reg;

  // Byte-lane bits of the word address carry no information for a word fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^WordAddress[1:0];

  // ---------------------------------------------------------------------------
  // Control FSM with registered AXI handshakes and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg    <= S_IDLE;
      abort_reg    <= 1'b0;
      beat_reg     <= '0;
      crit_reg     <= '0;
      ARVALID      <= 1'b0;
      RREADY       <= 1'b0;
      ARADDR       <= '0;
      LineAddress  <= '0;
      CritData     <= '0;
      LB_FirstWord <= 1'b0;
      LB_Completed <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (LB_Enable) begin
            ARADDR       <= {WordAddress[ADDR_W-1:2], 2'b00};
            LineAddress  <= {WordAddress[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            crit_reg     <= WordAddress[OFF_W-1:2];
            beat_reg     <= '0;
            abort_reg    <= 1'b0;
            LB_FirstWord <= 1'b0;
            LB_Completed <= 1'b0;
            ARVALID      <= 1'b1;
            state_reg    <= S_ADDR;
          end
        end

        S_ADDR: begin
          // The burst cannot be cancelled; remember the abort and keep going.
          if (!LB_Enable) abort_reg <= 1'b1;
          if (ARREADY) begin
            ARVALID   <= 1'b0;
            RREADY    <= 1'b1;
            state_reg <= S_DATA;
          end
        end

        S_DATA: begin
          if (!LB_Enable) abort_reg <= 1'b1;
          if (RVALID) begin
            beat_reg <= beat_reg + IDX_W'(1);
            if (beat_reg == '0) begin
              CritData     <= RDATA;
              LB_FirstWord <= 1'b1;
            end
            // Completion is counted, not taken from RLAST.
            if (last_beat) begin
              RREADY <= 1'b0;
              if (abort_reg || !LB_Enable) begin
                LB_FirstWord <= 1'b0;
                state_reg    <= S_IDLE;
              end else begin
                LB_Completed <= 1'b1;
                state_reg    <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          if (!LB_Enable) begin
            LB_FirstWord <= 1'b0;
            LB_Completed <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line storage: one register per slot, written when its slot comes up
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_slot
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          word_reg <= '0;
        end else if (beat_fire && (slot_idx == IDX_W'(gi))) begin
          word_reg <= RDATA;
        end
      end

      assign LineData[gi*DATA_W +: DATA_W] = word_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response checking
  // ---------------------------------------------------------------------------
`ifdef LFB_RESP_CHECK_EN
  logic error_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      error_reg <= 1'b0;
    end else if ((state_reg == S_IDLE) && LB_Enable) begin
      error_reg <= 1'b0;
    end else if (beat_fire && ((RRESP != 2'b00) || (RLAST != last_beat))) begin
      error_reg <= 1'b1;
    end
  end

  assign LB_Error = error_reg;
`else
  logic unused_resp;
  assign unused_resp = ^{RRESP, RLAST};
  assign LB_Error    = 1'b0;
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_fill_buffer
//
// Directed bench for line_fill_buffer. The AXI slave is played cycle by cycle
// from a single initial block; expected values are hand-derived constants or
// built from the stimulus data.
// -----------------------------------------------------------------------------
module tb_line_fill_buffer;

`ifdef LFB_RESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         LB_Enable = 1'b0;
  logic [31:0]  WordAddress = '0;
  logic         LB_FirstWord;
  logic         LB_Completed;
  logic [31:0]  LineAddress;
  logic [31:0]  CritData;
  logic [255:0] LineData;
  logic         LB_Error;
  logic [31:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic         ARVALID;
  logic         ARREADY = 1'b0;
  logic [31:0]  RDATA = '0;
  logic [1:0]   RRESP = '0;
  logic         RLAST = 1'b0;
  logic         RVALID = 1'b0;
  logic         RREADY;

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_line;

  line_fill_buffer #(
    .WORDS_PER_LINE(8),
    .DATA_W        (32),
    .ADDR_W        (32)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .LB_Enable   (LB_Enable),
    .WordAddress (WordAddress),
    .LB_FirstWord(LB_FirstWord),
    .LB_Completed(LB_Completed),
    .LineAddress (LineAddress),
    .CritData    (CritData),
    .LineData    (LineData),
    .LB_Error    (LB_Error),
    .ARADDR      (ARADDR),
    .ARLEN       (ARLEN),
    .ARSIZE      (ARSIZE),
    .ARBURST     (ARBURST),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RLAST       (RLAST),
    .RVALID      (RVALID),
    .RREADY      (RREADY)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One complete fill as seen from the controller and the AXI slave.
  //   ar_wait     : cycles ARREADY stays low while ARVALID is up
  //   toggle      : insert an RVALID=0 cycle between beats
  //   err_beat    : beat index answered with RRESP=SLVERR (-1 = none)
  //   abort_after : drop LB_Enable after this many beats (-1 = no abort)
  task automatic fill(input logic [31:0] addr, input logic [31:0] base,
                      input int ar_wait, input bit toggle,
                      input int err_beat, input int abort_after,
                      output logic [255:0] line_out);
    logic [31:0] araddr_exp;
    logic [2:0]  crit;
    bit          aborted;
    bit          err_seen;
    araddr_exp = {addr[31:2], 2'b00};
    crit       = addr[4:2];
    aborted    = 1'b0;
    err_seen   = 1'b0;
    line_out   = '0;
    for (int k = 0; k < 8; k++) begin
      line_out[32*((int'(crit) + k) % 8) +: 32] = base + 32'(k);
    end

    LB_Enable   = 1'b1;
    WordAddress = addr;
    step();
    $display("fill start addr=%08h", addr);
    chk("arvalid_start", 256'(ARVALID), 256'(1));
    chk("araddr", 256'(ARADDR), 256'(araddr_exp));
    chk("arlen", 256'(ARLEN), 256'(7));
    chk("arsize", 256'(ARSIZE), 256'(2));
    chk("arburst", 256'(ARBURST), 256'(2));
    chk("lineaddr_start", 256'(LineAddress), 256'({addr[31:5], 5'b0}));
    chk("error_cleared", 256'(LB_Error), 256'(0));
    chk("flags_cleared", 256'({LB_FirstWord, LB_Completed}), 256'(0));

    for (int i = 0; i < ar_wait; i++) begin
      ARREADY = 1'b0;
      step();
      chk("arvalid_hold", 256'(ARVALID), 256'(1));
      chk("araddr_stable", 256'(ARADDR), 256'(araddr_exp));
    end
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    chk("arvalid_drop", 256'(ARVALID), 256'(0));

    for (int k = 0; k < 8; k++) begin
      if (toggle && k > 0) begin
        RVALID = 1'b0;
        step();
        chk("gap_not_done", 256'(LB_Completed), 256'(0));
      end
      chk("rready", 256'(RREADY), 256'(1));
      RVALID = 1'b1;
      RDATA  = base + 32'(k);
      RRESP  = (k == err_beat) ? 2'b10 : 2'b00;
      RLAST  = (k == 7);
      step();
      RVALID = 1'b0;
      RRESP  = 2'b00;
      RLAST  = 1'b0;
      $display("beat %0d data=%08h", k, base + 32'(k));
      if (k == err_beat) err_seen = 1'b1;
      chk("error_flag", 256'(LB_Error), 256'(ERR_EN && err_seen));
      if (k == 0) begin
        chk("first_word", 256'(LB_FirstWord), 256'(1));
        chk("crit_data", 256'(CritData), 256'(base));
      end
      if (k < 7) chk("not_done", 256'(LB_Completed), 256'(0));
      if (k + 1 == abort_after) begin
        LB_Enable = 1'b0;
        aborted   = 1'b1;
      end
    end

    if (aborted) begin
      chk("abort_no_done", 256'(LB_Completed), 256'(0));
      chk("abort_first_clr", 256'(LB_FirstWord), 256'(0));
      chk("abort_rready", 256'(RREADY), 256'(0));
      step();
      chk("abort_idle_no_ar", 256'(ARVALID), 256'(0));
    end else begin
      chk("done", 256'(LB_Completed), 256'(1));
      chk("done_rready", 256'(RREADY), 256'(0));
      chk("done_first", 256'(LB_FirstWord), 256'(1));
      chk("lineaddr", 256'(LineAddress), 256'({addr[31:5], 5'b0}));
      chk("line_data", LineData, line_out);
    end
  endtask

  // Hold LB_Enable in DONE for n cycles, then acknowledge.
  task automatic release_line(input int n, input logic [255:0] line, input logic [31:0] crit_exp);
    for (int i = 0; i < n; i++) begin
      step();
      chk("done_held", 256'(LB_Completed), 256'(1));
    end
    LB_Enable = 1'b0;
    step();
    $display("release after %0d hold cycles", n);
    chk("release_done_clr", 256'(LB_Completed), 256'(0));
    chk("release_first_clr", 256'(LB_FirstWord), 256'(0));
    chk("release_line_kept", LineData, line);
    chk("release_crit_kept", 256'(CritData), 256'(crit_exp));
    step();
    chk("idle_no_ar", 256'(ARVALID), 256'(0));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_arvalid", 256'(ARVALID), 256'(0));
    chk("rst_rready", 256'(RREADY), 256'(0));
    chk("rst_flags", 256'({LB_FirstWord, LB_Completed, LB_Error}), 256'(0));
    chk("rst_araddr", 256'(ARADDR), 256'(0));
    chk("rst_lineaddr", 256'(LineAddress), 256'(0));
    chk("rst_crit", 256'(CritData), 256'(0));
    chk("rst_line", LineData, 256'(0));
    step();
    Rst = 1'b1;
    step();
    chk("idle_after_rst", 256'(ARVALID), 256'(0));

    // Aligned fill, critical word 0, hold DONE 5 cycles
    fill(32'h0000_1040, 32'hA0, 0, 1'b0, -1, -1, exp_line);
    chk("aligned_word0", 256'(LineData[31:0]), 256'(32'hA0));
    chk("aligned_word7", 256'(LineData[255:224]), 256'(32'hA7));
    release_line(5, exp_line, 32'hA0);

    // Wrap fill, critical word 7
    fill(32'h0000_205C, 32'hB0, 0, 1'b0, -1, -1, exp_line);
    chk("wrap_word7", 256'(LineData[255:224]), 256'(32'hB0));
    chk("wrap_word0", 256'(LineData[31:0]), 256'(32'hB1));
    chk("wrap_word6", 256'(LineData[223:192]), 256'(32'hB7));
    release_line(1, exp_line, 32'hB0);

    // Backpressure: ARREADY late, RVALID toggling, critical word 3
    fill(32'h0000_108C, 32'hC0, 3, 1'b1, -1, -1, exp_line);
    chk("bp_word3", 256'(LineData[127:96]), 256'(32'hC0));
    chk("bp_word2", 256'(LineData[95:64]), 256'(32'hC7));
    release_line(1, exp_line, 32'hC0);

    // Abort after three beats, then a normal fill at 0x3000
    fill(32'h0000_2220, 32'h90, 0, 1'b0, -1, 3, exp_line);
    fill(32'h0000_3000, 32'hD0, 0, 1'b0, -1, -1, exp_line);
    release_line(2, exp_line, 32'hD0);

    // Error response on beat 4
    fill(32'h0000_4010, 32'hE0, 0, 1'b0, 4, -1, exp_line);
    release_line(1, exp_line, 32'hE0);
    chk("error_sticky_idle", 256'(LB_Error), 256'(ERR_EN));

    // Next fill clears the error; reset mid-burst aborts it
    LB_Enable   = 1'b1;
    WordAddress = 32'h0000_5004;
    step();
    chk("error_clr_on_start", 256'(LB_Error), 256'(0));
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RDATA   = 32'h55;
    step();
    RVALID = 1'b0;
    chk("midrst_first", 256'(LB_FirstWord), 256'(1));
    #2;
    Rst = 1'b0;
    #1;
    $display("async reset mid-burst");
    chk("midrst_rready", 256'(RREADY), 256'(0));
    chk("midrst_first_clr", 256'(LB_FirstWord), 256'(0));
    chk("midrst_line", LineData, 256'(0));
    chk("midrst_araddr", 256'(ARADDR), 256'(0));
    LB_Enable = 1'b0;
    step();
    Rst = 1'b1;
    step();
    chk("post_rst_idle", 256'({ARVALID, RREADY}), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
